spi_target_core: RTL and testbench
==================================

Name: spi_target_core

Overview:
- SPI mode-0 target (responder), the far end of the SPI host link, for loopback and bring-up of the host on the same die.
- Oversamples an external SCK/CSB/SD in the clk_i domain.
- Deserialises MOSI words into an RX FIFO.
- Serialises words from a TX holding register onto MISO.

Parameters:
- DataWidth, 8, bits per SPI word; MSB first; legal range 4..32.
- RxDepth, 4, RX FIFO entries, ≥ 2. Count width = vbits(RxDepth+1), pointer width = vbits(RxDepth), both from prim_util_pkg.
- IdleTx, all ones, word shifted out when no TX data is available.

Ports:
- clk_i  in  1  system clock; fclk ≥ 8 × fsck.
- rst_ni  in  1  synchronous, active-low reset.
- spi_sck_i  in  1  SPI clock, asynchronous to clk_i.
- spi_csb_i  in  1  chip select, active low, asynchronous.
- spi_sd_i  in  1  MOSI, asynchronous.
- spi_sd_o  out  1  MISO data.
- spi_sd_en_o  out  1  MISO output enable; high only while selected.
- rx_data_o  out  DataWidth  RX FIFO head.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  pop when rx_valid_o && rx_ready_i.
- tx_data_i  in  DataWidth  next word to transmit.
- tx_valid_i  in  1  TX word offered.
- tx_ready_o  out  1  holding register empty.
- rx_overflow_o  out  1  one-cycle pulse: received word dropped because FIFO full.
- tx_underflow_o  out  1  one-cycle pulse: IdleTx used because holding register empty.
- active_o  out  1  FSM in ACTIVE.

Behaviour:
- Reset (rst_ni low at a clk_i edge) sets all state:
  - FSM to IDLE; synchronisers to sck=0, csb=1, sd=0.
  - RX FIFO emptied; TX holding register empty.
  - spi_sd_o=1, spi_sd_en_o=0, rx_valid_o=0, tx_ready_o=1, pulses=0, active_o=0.
  - Reset mid-frame discards the partial word and FIFO contents.
- Synchronisation: 2-flop synchroniser per SPI input, then one edge-detect register.
  - sck_rise, sck_fall, csb_fall and csb_rise are single-cycle strobes, 3 clk_i cycles after the pin edge.
- TX holding register:
  - Accept when tx_valid_i && tx_ready_o.
  - tx_ready_o is low while full and returns high the cycle after the register is consumed into the shifter.
  - Consume and accept in the same cycle is not allowed: tx_ready_o is registered.
- FSM IDLE → ACTIVE on csb_fall. In the same cycle:
  - Load tx_shift from the holding register, or IdleTx with a tx_underflow_o pulse if empty.
  - Clear bit counter; assert spi_sd_en_o; spi_sd_o = tx_shift MSB.
- ACTIVE:
  - sck_rise: rx_shift = {rx_shift[DataWidth-2:0], sd_sync}; bit counter +1.
  - When the counter reaches DataWidth, the same cycle:
    - Word is pushed to the RX FIFO; counter wraps to 0.
    - Flag reload_pending is set.
  - sck_fall: if reload_pending, load tx_shift from holding register/IdleTx (underflow rule as above) and clear the flag; else shift tx_shift left by 1. spi_sd_o follows tx_shift MSB.
  - csb_rise → IDLE: partial rx word discarded; spi_sd_en_o=0, spi_sd_o=1.
  - If csb_rise and sck_rise coincide, csb_rise wins and no sample is taken.
  - A pending TX reload is dropped and the holding register is kept.
- RX FIFO:
  - Push when a word completes.
  - If full and no pop in the same cycle: word dropped, rx_overflow_o pulses, FIFO unchanged.
  - Simultaneous push and pop when full is accepted.
  - Pointers wrap modulo RxDepth; count saturates at RxDepth.
  - rx_data_o is valid combinationally from the head entry.
- Latency: rx_valid_o rises 4 clk_i cycles after the last SCK rising edge of a word at the pin (3 synchroniser/edge cycles + 1 FIFO write cycle).
- SCK edges while IDLE are ignored. CSB glitches shorter than 2 clk_i cycles are not guaranteed to be filtered.

Test Plan:
- Reset, then 1 frame of MOSI 0xA5 (DataWidth=8) with TX preloaded 0x3C → rx_data_o=0xA5 and rx_valid_o high 4 clk after the 8th SCK rise; MISO bits 0,0,1,1,1,1,0,0; no pulses.
- Frame with no TX loaded → MISO 0xFF, tx_underflow_o pulses once at csb_fall.
- 3-word burst 0x01,0x02,0x03 under one CSB; TX refilled each time tx_ready_o rises with 0x81,0x42,0x24 → RX pops 0x01,0x02,0x03 in order; MISO matches; active_o high throughout.
- 5 words, RxDepth=4, rx_ready_i=0 → the 5th word (0x55) dropped with one rx_overflow_o pulse; then pop 4 → 0x11,0x22,0x33,0x44, rx_valid_o falls.
- CSB deasserted after 5 SCK rises, then a full word 0xC3 → only 0xC3 is pushed; the partial word is discarded.
- rst_ni low for 1 cycle mid-word with 2 words in FIFO → next cycle rx_valid_o=0, spi_sd_en_o=0, tx_ready_o=1, active_o=0.

Source files
------------

// File: rtl/spi_target_if.sv
// Pin-level SPI signals plus RX/TX word streams of the SPI mode-0 target.
// The slave modport is the target core; the master modport is the host/bench side.
interface spi_target_if #(
  parameter int DataWidth = 8
);
  logic                 spi_sck_i;
  logic                 spi_csb_i;
  logic                 spi_sd_i;
  logic                 spi_sd_o;
  logic                 spi_sd_en_o;
  logic [DataWidth-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic [DataWidth-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic                 rx_overflow_o;
  logic                 tx_underflow_o;
  logic                 active_o;

  modport slave (
    input  spi_sck_i, spi_csb_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i,
    output spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underflow_o, active_o
  );

  modport master (
    output spi_sck_i, spi_csb_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underflow_o, active_o
  );
endinterface

// File: rtl/spi_target_core.sv
// SPI mode-0 target: oversamples SCK/CSB/SD in clk_i, deserialises MOSI words into
// an RX FIFO and serialises a TX holding register (or IdleTx) onto MISO.
module spi_target_core #(
  parameter int                   DataWidth = 8,
  parameter int                   RxDepth   = 4,
  parameter logic [DataWidth-1:0] IdleTx    = {DataWidth{1'b1}}
) (
  input logic         clk_i,
  input logic         rst_ni,
  spi_target_if.slave bus
);

  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int CntW = vbits(RxDepth + 1);
  localparam int PtrW = vbits(RxDepth);
  localparam int BitW = vbits(DataWidth);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e               state_r, state_d;
  logic [2:0]           sck_q_r, csb_q_r;
  logic [1:0]           sd_q_r;
  logic                 sck_rise_s, sck_fall_s, csb_rise_s, csb_fall_s;
  logic                 start_s, stop_s, sample_s, shift_s, load_s, word_done_s;
  logic [DataWidth-1:0] load_word_s, rx_word_s;
  logic [DataWidth-1:0] tx_shift_r, tx_hold_r, push_data_r;
  logic [DataWidth-2:0] rx_shift_r;
  logic                 tx_ready_r, tx_underflow_r, sd_en_r, reload_pending_r, push_r;
  logic [BitW-1:0]      bit_cnt_r;
  logic [DataWidth-1:0] mem_r [RxDepth];
  logic [PtrW-1:0]      wptr_r, rptr_r;
  logic [CntW-1:0]      count_r;
  logic                 rx_overflow_r, full_s, pop_s, wr_s, rx_valid_s;

  // Index [2] of each SCK/CSB chain is the edge-detect stage behind the 2-flop synchroniser.
  assign sck_rise_s  =  sck_q_r[1] & ~sck_q_r[2];
  assign sck_fall_s  = ~sck_q_r[1] &  sck_q_r[2];
  assign csb_rise_s  =  csb_q_r[1] & ~csb_q_r[2];
  assign csb_fall_s  = ~csb_q_r[1] &  csb_q_r[2];
  assign load_s      = start_s | (shift_s & reload_pending_r);
  assign load_word_s = tx_ready_r ? IdleTx : tx_hold_r;
  assign rx_word_s   = {rx_shift_r, sd_q_r[1]};
  assign word_done_s = sample_s && (bit_cnt_r == BitW'(DataWidth - 1));

  // Synchronisers and edge-detect registers for the asynchronous SPI pins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_q_r <= 3'b000;
      csb_q_r <= 3'b111;
      sd_q_r  <= 2'b00;
    end else begin
      sck_q_r <= {sck_q_r[1:0], bus.spi_sck_i};
      csb_q_r <= {csb_q_r[1:0], bus.spi_csb_i};
      sd_q_r  <= {sd_q_r[0], bus.spi_sd_i};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // FSM next state and per-cycle action strobes; CSB rise outranks a coincident SCK edge.
  always_comb begin
    state_d  = state_r;
    start_s  = 1'b0;
    stop_s   = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (csb_fall_s) begin
          state_d = ST_ACTIVE;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (csb_rise_s) begin
          state_d = ST_IDLE;
          stop_s  = 1'b1;
        end else if (sck_rise_s) begin
          sample_s = 1'b1;
        end else if (sck_fall_s) begin
          shift_s = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX holding register, MISO shifter and output enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_shift_r       <= {DataWidth{1'b1}};
      tx_hold_r        <= {DataWidth{1'b0}};
      tx_ready_r       <= 1'b1;
      tx_underflow_r   <= 1'b0;
      sd_en_r          <= 1'b0;
      reload_pending_r <= 1'b0;
    end else begin
      tx_underflow_r <= load_s & tx_ready_r;
      if (load_s) begin
        tx_shift_r <= load_word_s;
      end else if (shift_s) begin
        tx_shift_r <= {tx_shift_r[DataWidth-2:0], 1'b1};
      end else if (stop_s) begin
        tx_shift_r <= {DataWidth{1'b1}};
      end else begin
        tx_shift_r <= tx_shift_r;
      end
      // A full register is never accepted into, so consume and accept cannot collide.
      if (load_s && !tx_ready_r) begin
        tx_ready_r <= 1'b1;
      end else if (bus.tx_valid_i && tx_ready_r) begin
        tx_hold_r  <= bus.tx_data_i;
        tx_ready_r <= 1'b0;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
      if (start_s) begin
        sd_en_r <= 1'b1;
      end else if (stop_s) begin
        sd_en_r <= 1'b0;
      end else begin
        sd_en_r <= sd_en_r;
      end
      if (start_s || stop_s || (shift_s && reload_pending_r)) begin
        reload_pending_r <= 1'b0;
      end else if (word_done_s) begin
        reload_pending_r <= 1'b1;
      end else begin
        reload_pending_r <= reload_pending_r;
      end
    end
  end

  // MOSI deserialiser and bit counter; a completed word is staged for the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_shift_r  <= {(DataWidth-1){1'b0}};
      bit_cnt_r   <= {BitW{1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {DataWidth{1'b0}};
    end else begin
      push_r <= word_done_s;
      if (word_done_s) begin
        push_data_r <= rx_word_s;
      end else begin
        push_data_r <= push_data_r;
      end
      if (start_s || stop_s) begin
        rx_shift_r <= {(DataWidth-1){1'b0}};
        bit_cnt_r  <= {BitW{1'b0}};
      end else if (sample_s) begin
        rx_shift_r <= rx_word_s[DataWidth-2:0];
        bit_cnt_r  <= word_done_s ? {BitW{1'b0}} : bit_cnt_r + BitW'(1'b1);
      end else begin
        rx_shift_r <= rx_shift_r;
        bit_cnt_r  <= bit_cnt_r;
      end
    end
  end

  assign rx_valid_s = (count_r != {CntW{1'b0}});
  assign full_s     = (count_r == CntW'(RxDepth));
  assign pop_s      = rx_valid_s & bus.rx_ready_i;
  assign wr_s       = push_r & (~full_s | pop_s);

  // RX FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_r        <= {PtrW{1'b0}};
      rptr_r        <= {PtrW{1'b0}};
      count_r       <= {CntW{1'b0}};
      rx_overflow_r <= 1'b0;
    end else begin
      rx_overflow_r <= push_r & full_s & ~pop_s;
      if (wr_s) begin
        wptr_r <= (wptr_r == PtrW'(RxDepth - 1)) ? {PtrW{1'b0}} : wptr_r + PtrW'(1'b1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= (rptr_r == PtrW'(RxDepth - 1)) ? {PtrW{1'b0}} : rptr_r + PtrW'(1'b1);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1'b1);
        2'b01:   count_r <= count_r - CntW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // RX FIFO storage; emptiness is tracked by count_r, so entries need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_r[wptr_r] <= push_data_r;
    end
  end

  assign bus.spi_sd_o       = tx_shift_r[DataWidth-1];
  assign bus.spi_sd_en_o    = sd_en_r;
  assign bus.rx_data_o      = mem_r[rptr_r];
  assign bus.rx_valid_o     = rx_valid_s;
  assign bus.tx_ready_o     = tx_ready_r;
  assign bus.rx_overflow_o  = rx_overflow_r;
  assign bus.tx_underflow_o = tx_underflow_r;
  assign bus.active_o       = (state_r == ST_ACTIVE);

endmodule

// File: tb/tb_spi_target_core.sv
// Directed bench for spi_target_core: table of single-word frames plus hand-written
// burst, overflow, partial-word and mid-frame reset sequences.
module tb_spi_target_core;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   uf_cnt = 0;
  int   ov_cnt = 0;

  always #5 clk = ~clk;

  spi_target_if #(.DataWidth(8)) bus ();

  spi_target_core #(.DataWidth(8), .RxDepth(4), .IdleTx(8'hFF)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.tx_underflow_o === 1'b1) uf_cnt++;
    if (bus.rx_overflow_o === 1'b1) ov_cnt++;
  end

  typedef struct {
    logic [7:0] mosi;
    logic       tx_load;
    logic [7:0] tx;
    logic [7:0] exp_miso;
    int         exp_uf;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    int w = 0;
    while (bus.tx_ready_o !== 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    chk("tx_ready_wait", {31'd0, bus.tx_ready_o}, 32'd1);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    tick(1);
    bus.tx_valid_i = 1'b0;
    chk("tx_ready_after_load", {31'd0, bus.tx_ready_o}, 32'd0);
  endtask

  // Shift nbits of mosi (MSB first); on the last bit of a frame CSB rises with the SCK fall.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input logic end_frame,
                      output logic [7:0] miso, output int lat, output logic en_ok);
    miso  = 8'h00;
    lat   = 0;
    en_ok = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_sd_i = mosi[7-i];
      tick(HALF);
      miso = {miso[6:0], bus.spi_sd_o};
      if (bus.spi_sd_en_o !== 1'b1 || bus.active_o !== 1'b1) en_ok = 1'b0;
      bus.spi_sck_i = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        tick(1);
        if (lat == 0 && bus.rx_valid_o === 1'b1) lat = k;
      end
      if (end_frame && i == nbits - 1) bus.spi_csb_i = 1'b1;
      bus.spi_sck_i = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mosi, output logic [7:0] miso, output int lat,
                       output logic en_ok);
    bus.spi_csb_i = 1'b0;
    tick(HALF);
    xfer(mosi, 8, 1'b1, miso, lat, en_ok);
    tick(HALF);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, {31'd0, bus.rx_valid_o}, 32'd1);
    chk({nm, "_data"}, {24'd0, bus.rx_data_o}, {24'd0, exp});
    bus.rx_ready_i = 1'b1;
    tick(1);
    bus.rx_ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] miso;
    logic [7:0] ow [5];
    logic [7:0] bw [3];
    logic [7:0] bm [3];
    int         lat;
    int         uf0, ov0;
    logic       en_ok;

    vecs[0] = '{mosi: 8'hA5, tx_load: 1'b1, tx: 8'h3C, exp_miso: 8'h3C, exp_uf: 0};
    vecs[1] = '{mosi: 8'h5A, tx_load: 1'b0, tx: 8'h00, exp_miso: 8'hFF, exp_uf: 1};
    vecs[2] = '{mosi: 8'h00, tx_load: 1'b1, tx: 8'hFF, exp_miso: 8'hFF, exp_uf: 0};
    vecs[3] = '{mosi: 8'hFF, tx_load: 1'b1, tx: 8'h00, exp_miso: 8'h00, exp_uf: 0};
    vecs[4] = '{mosi: 8'h96, tx_load: 1'b1, tx: 8'h69, exp_miso: 8'h69, exp_uf: 0};
    ow = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bw = '{8'h01, 8'h02, 8'h03};
    bm = '{8'h81, 8'h42, 8'h24};

    bus.spi_sck_i  = 1'b0;
    bus.spi_csb_i  = 1'b1;
    bus.spi_sd_i   = 1'b0;
    bus.rx_ready_i = 1'b0;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    rst_n          = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    chk("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
    chk("rst_sd_en", {31'd0, bus.spi_sd_en_o}, 32'd0);
    chk("rst_sd_o", {31'd0, bus.spi_sd_o}, 32'd1);
    chk("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
    chk("rst_active", {31'd0, bus.active_o}, 32'd0);
    chk("rst_pulses", {30'd0, bus.rx_overflow_o, bus.tx_underflow_o}, 32'd0);

    // SCK toggling with CSB high must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.spi_sck_i = 1'b1;
      tick(HALF);
      bus.spi_sck_i = 1'b0;
      tick(HALF);
    end
    chk("idle_sck_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
    chk("idle_sck_active", {31'd0, bus.active_o}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].tx_load) load_tx(vecs[v].tx);
      uf0 = uf_cnt;
      ov0 = ov_cnt;
      frame(vecs[v].mosi, miso, lat, en_ok);
      tick(2);
      chk($sformatf("v%0d_miso", v), {24'd0, miso}, {24'd0, vecs[v].exp_miso});
      chk($sformatf("v%0d_latency", v), lat, 32'd4);
      chk($sformatf("v%0d_en_active", v), {31'd0, en_ok}, 32'd1);
      chk($sformatf("v%0d_underflow", v), uf_cnt - uf0, vecs[v].exp_uf);
      chk($sformatf("v%0d_overflow", v), ov_cnt - ov0, 32'd0);
      chk($sformatf("v%0d_sd_en_off", v), {31'd0, bus.spi_sd_en_o}, 32'd0);
      chk($sformatf("v%0d_sd_o_idle", v), {31'd0, bus.spi_sd_o}, 32'd1);
      pop_chk($sformatf("v%0d_rx", v), vecs[v].mosi);
      chk($sformatf("v%0d_rx_empty", v), {31'd0, bus.rx_valid_o}, 32'd0);
    end

    // Three-word burst under one CSB with the holding register refilled as it drains.
    load_tx(8'h81);
    uf0 = uf_cnt;
    bus.spi_csb_i = 1'b0;
    tick(HALF);
    load_tx(8'h42);
    for (int w = 0; w < 3; w++) begin
      xfer(bw[w], 8, (w == 2), miso, lat, en_ok);
      chk($sformatf("burst%0d_miso", w), {24'd0, miso}, {24'd0, bm[w]});
      chk($sformatf("burst%0d_active", w), {31'd0, en_ok}, 32'd1);
      if (w == 0) load_tx(8'h24);
    end
    tick(HALF);
    chk("burst_underflow", uf_cnt - uf0, 32'd0);
    for (int w = 0; w < 3; w++) pop_chk($sformatf("burst%0d_rx", w), bw[w]);
    chk("burst_rx_empty", {31'd0, bus.rx_valid_o}, 32'd0);

    // Five words into a four-entry FIFO with no pops: the fifth is dropped.
    uf0 = uf_cnt;
    ov0 = ov_cnt;
    bus.spi_csb_i = 1'b0;
    tick(HALF);
    for (int w = 0; w < 5; w++) xfer(ow[w], 8, (w == 4), miso, lat, en_ok);
    tick(HALF);
    chk("ovf_pulses", ov_cnt - ov0, 32'd1);
    chk("ovf_underflows", uf_cnt - uf0, 32'd5);
    for (int w = 0; w < 4; w++) pop_chk($sformatf("ovf%0d_rx", w), ow[w]);
    chk("ovf_rx_empty", {31'd0, bus.rx_valid_o}, 32'd0);

    // CSB released after five SCK rises, then one full word.
    bus.spi_csb_i = 1'b0;
    tick(HALF);
    xfer(8'hE8, 5, 1'b1, miso, lat, en_ok);
    tick(HALF);
    chk("partial_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
    chk("partial_active", {31'd0, bus.active_o}, 32'd0);
    frame(8'hC3, miso, lat, en_ok);
    tick(2);
    pop_chk("partial_then_full_rx", 8'hC3);
    chk("partial_rx_empty", {31'd0, bus.rx_valid_o}, 32'd0);

    // Reset mid-word with two words queued and the holding register full.
    frame(8'h12, miso, lat, en_ok);
    frame(8'h34, miso, lat, en_ok);
    tick(2);
    chk("pre_reset_rx_valid", {31'd0, bus.rx_valid_o}, 32'd1);
    bus.spi_csb_i = 1'b0;
    tick(HALF);
    load_tx(8'h77);
    xfer(8'hF0, 3, 1'b0, miso, lat, en_ok);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
    chk("mid_rst_sd_en", {31'd0, bus.spi_sd_en_o}, 32'd0);
    chk("mid_rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
    chk("mid_rst_active", {31'd0, bus.active_o}, 32'd0);
    chk("mid_rst_sd_o", {31'd0, bus.spi_sd_o}, 32'd1);
    bus.spi_csb_i = 1'b1;
    tick(10);
    load_tx(8'h5A);
    frame(8'hE7, miso, lat, en_ok);
    tick(2);
    chk("post_rst_miso", {24'd0, miso}, 32'h5A);
    pop_chk("post_rst_rx", 8'hE7);
    chk("post_rst_rx_empty", {31'd0, bus.rx_valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
